mbr4_iter_td: RTL and testbench

Parametrised iterative radix-4 Booth multiplier with valid/ready handshakes on input and output. It is the next generation of the registered-I/O Booth multiplier test driver: WIDTH is configurable and a per-operation signed/unsigned mode is added. It retires one Booth digit per clock and holds its result under output backpressure. It sits between an operand source and a result consumer in the multiplier evaluation datapath.

---
 rtl/mbr4_pkg.sv | 43 ++++
 rtl/mbr4_booth_sel.sv | 29 ++
 rtl/mbr4_iter_td.sv | 117 +++++++++++
 tb/tb_mbr4_iter_td.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mbr4_pkg.sv
// rtl/mbr4_pkg.sv - shared state/digit types and sizing helpers for the radix-4 Booth multiplier
package mbr4_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } mbr4_state_e;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_P1,
    BD_P2,
    BD_M1,
    BD_M2
  } booth_digit_e;

  function automatic int mbr4_ew(input int width);
    return width + 2;
  endfunction

  function automatic int mbr4_n(input int width);
    return (width + 2) / 2;
  endfunction

  function automatic bit mbr4_width_ok(input int width);
    return (width >= 4) && ((width % 2) == 0);
  endfunction

  // Window is {y[2i+1], y[2i], y[2i-1]}
  function automatic booth_digit_e booth_recode(input logic [2:0] win);
    booth_digit_e d;
    case (win)
      3'b001, 3'b010: d = BD_P1;
      3'b011:         d = BD_P2;
      3'b100:         d = BD_M2;
      3'b101, 3'b110: d = BD_M1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mbr4_booth_sel.sv
// rtl/mbr4_booth_sel.sv - combinational Booth partial-product selector
module mbr4_booth_sel
  import mbr4_pkg::*;
#(
  parameter int PW = 18
) (
  input  logic [2:0]    win,
  input  logic [PW-1:0] mcand,
  output logic [PW-1:0] pp
);

  booth_digit_e dig;
  logic [PW-1:0] mcand_x2;

  assign mcand_x2 = {mcand[PW-2:0], 1'b0};

  always_comb begin
    dig = booth_recode(win);
    pp  = '0;
    case (dig)
      BD_P1:   pp = mcand;
      BD_P2:   pp = mcand_x2;
      BD_M1:   pp = -mcand;
      BD_M2:   pp = -mcand_x2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/mbr4_iter_td.sv
// rtl/mbr4_iter_td.sv - iterative radix-4 Booth multiplier, one digit per clock, valid/ready I/O
// Optional MBR4_ZERO_SKIP_EN: a zero operand bypasses RUN and completes with product 0.
module mbr4_iter_td
  import mbr4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mx,
  input  logic [WIDTH-1:0]   my,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int EW = mbr4_ew(WIDTH);
  localparam int N  = mbr4_n(WIDTH);
  localparam int AW = 2 * WIDTH + 2;
  localparam int CW = $clog2(N);

`ifdef MBR4_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  if (!mbr4_width_ok(WIDTH)) begin : g_width_check
    $error("mbr4_iter_td: WIDTH must be even and >= 4");
  end

  mbr4_state_e   state_q, state_d;
  logic [AW-1:0] mcand_q;
  logic [EW:0]   mplr_q;
  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;

  logic          accept;
  logic          zero_skip;
  logic          last_digit;
  logic [AW-1:0] mx_ext;
  logic [EW-1:0] my_ext;
  logic [AW-1:0] pp;
  logic [AW-1:0] acc_sum;

  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign zero_skip  = ZSKIP && ((mx == '0) || (my == '0));
  assign last_digit = (cnt_q == CW'(N - 1));

  // Unsigned operands gain zero top bits so the signed Booth recoding stays exact
  assign mx_ext = {{(AW - WIDTH){mx[WIDTH-1] & is_signed}}, mx};
  assign my_ext = {{(EW - WIDTH){my[WIDTH-1] & is_signed}}, my};

  mbr4_booth_sel #(.PW(AW)) u_sel (
    .win   (mplr_q[2:0]),
    .mcand (mcand_q),
    .pp    (pp)
  );

  assign acc_sum = acc_q + pp;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = zero_skip ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (last_digit) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (accept) state_d = zero_skip ? S_DONE : S_RUN;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplicand moves left two places per digit instead of a variable 4^i shift
  always_ff @(posedge CLK) begin
    if (RST) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else if (accept) begin
      mcand_q <= mx_ext;
      mplr_q  <= {my_ext, 1'b0};
      acc_q   <= '0;
      cnt_q   <= '0;
      if (zero_skip) product <= '0;
    end else if (state_q == S_RUN) begin
      acc_q   <= acc_sum;
      mcand_q <= {mcand_q[AW-3:0], 2'b00};
      mplr_q  <= {2'b00, mplr_q[EW:2]};
      cnt_q   <= cnt_q + CW'(1);
      if (last_digit) product <= acc_sum[2*WIDTH-1:0];
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_mbr4_iter_td.sv
// tb/tb_mbr4_iter_td.sv - directed vector bench for mbr4_iter_td at WIDTH = 8
module tb_mbr4_iter_td;

  localparam int W = 8;
`ifdef MBR4_ZERO_SKIP_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 5;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   mx = '0;
  logic [W-1:0]   my = '0;
  logic           is_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] product;
  logic           busy;

  int checks = 0;
  int errors = 0;

  mbr4_iter_td #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mx        (mx),
    .my        (my),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         s;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [15:0]  exp;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits from the negedge after an accept edge; lat counts edges until out_valid shows
  task automatic wait_result(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({name, "_run_in_ready"}, in_ready, 0);
      check({name, "_run_busy"}, busy, 1);
      @(negedge CLK);
      lat++;
    end
    check({name, "_timeout"}, out_valid, 1);
  endtask

  task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input int exp_lat, input string name);
    int lat;
    check({name, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; is_signed = s; mx = a; my = b;
    @(negedge CLK);
    in_valid = 1'b0;
    wait_result(name, lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_product"}, product, exp);
    @(negedge CLK);
    check({name, "_single_xfer"}, out_valid, 0);
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000, 5};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 5};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 5};
    vecs[3] = '{1'b0, 8'h03, 8'h05, 16'h000F, 5};
    vecs[4] = '{1'b1, 8'h7F, 8'h80, 16'hC080, 5};
    vecs[5] = '{1'b0, 8'h80, 8'h80, 16'h4000, 5};
    vecs[6] = '{1'b1, 8'hFE, 8'h03, 16'hFFFA, 5};
    vecs[7] = '{1'b0, 8'h12, 8'h34, 16'h03A8, 5};
    vecs[8] = '{1'b1, 8'h00, 8'h5A, 16'h0000, ZLAT};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++)
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // Output backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; is_signed = 1'b1; mx = 8'hFF; my = 8'h01;
    @(negedge CLK);
    in_valid = 1'b0;
    wait_result("bp", lat);
    in_valid = 1'b1; mx = 8'h11; my = 8'h22;
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_product", product, 16'hFFFF);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_idle", in_ready, 1);
    check("bp_release_busy", busy, 0);

    // Back-to-back with overlapped accept
    in_valid = 1'b1; is_signed = 1'b0; mx = 8'd3; my = 8'd5;
    @(negedge CLK);
    mx = 8'd7; my = 8'd9;
    wait_result("b2b1", lat);
    check("b2b1_lat", lat, 5);
    check("b2b1_product", product, 16'h000F);
    check("b2b1_in_ready", in_ready, 1);
    @(negedge CLK);
    in_valid = 1'b0;
    check("b2b2_accepted_busy", busy, 1);
    check("b2b2_valid_low", out_valid, 0);
    wait_result("b2b2", lat);
    check("b2b2_lat", lat, 5);
    check("b2b2_product", product, 16'h003F);
    @(negedge CLK);
    check("b2b2_single_xfer", out_valid, 0);

    // Reset mid-RUN discards the operation
    in_valid = 1'b1; is_signed = 1'b0; mx = 8'h12; my = 8'h34;
    @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_product", product, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      check("midrst_no_output", out_valid, 0);
    end
    do_op(1'b0, 8'h02, 8'h03, 16'h0006, 5, "post_rst");

    // Zero operand: no RUN phase when skipping
    in_valid = 1'b1; is_signed = 1'b0; mx = 8'h00; my = 8'h5A;
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check("zero_lat", lat, ZLAT);
    check("zero_product", product, 0);
    check("zero_busy_at_done", busy, 0);
    @(negedge CLK);
    check("zero_single_xfer", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

endmodule
